// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch-stage types and constants
// Contents: fetch_state_t enum, NOP word, PC increment, default XLEN.
package instr_fetch_unit_pkg;
  localparam int DEF_XLEN = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: sequential pc, redirect target and misalignment flag
// Ports: pc, base, imm, is_jalr in; pc_inc, target, misaligned out.
// Macro FETCH_MISALIGN_TRAP_EN: defined flags target[1:0]!=0, undefined forces target[1:0]=0.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic            is_jalr,
  output logic [XLEN-1:0] pc_inc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  logic [XLEN-1:0] sum;
  always_comb begin
    sum = base + imm;
    pc_inc = pc + XLEN'(PC_INC);
    target = {sum[XLEN-1:1], sum[0] & ~is_jalr};
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = |target[1:0];
`else
    target[1:0] = 2'b00;
    misaligned = 1'b0;
`endif
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage with req/ack imem handshake and redirect handling
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata to memory;
//   instr_out/pc_out/instr_valid/instr_ready to decode; redirect, redirect_is_jalr,
//   redirect_base, immediate from execute; fetch_fault misaligned-target trap.
// Macro FETCH_MISALIGN_TRAP_EN enables the FAULT state; otherwise fetch_fault is tied 0.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic            redirect_is_jalr,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] immediate,
  output logic            fetch_fault
);
  fetch_state_t    state;
  logic [XLEN-1:0] pc, stale, pc_inc, target;
  logic            started, flt_pend, misaligned, ack;
  next_pc_calc #(.XLEN(XLEN)) u_npc (
    .pc(pc),
    .base(redirect_base),
    .imm(immediate),
    .is_jalr(redirect_is_jalr),
    .pc_inc(pc_inc),
    .target(target),
    .misaligned(misaligned)
  );
  // started delays the first request to the cycle after reset is released
  assign imem_req = started && (state == FETCH || state == DISCARD);
  assign imem_addr = state == DISCARD ? stale : pc;
  assign instr_valid = state == HOLD;
  assign ack = imem_ack && imem_req;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = state == FAULT;
`else
  assign fetch_fault = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      stale <= RESET_PC;
      started <= 1'b0;
      flt_pend <= 1'b0;
      instr_out <= NOP;
      pc_out <= RESET_PC;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH:
          if (redirect) begin
            pc <= target;
            // an unanswered request must still complete at its original address
            if (ack || !imem_req) state <= misaligned ? FAULT : FETCH;
            else begin
              stale <= pc;
              flt_pend <= misaligned;
              state <= DISCARD;
            end
          end else if (ack) begin
            instr_out <= imem_rdata;
            pc_out <= pc;
            state <= HOLD;
          end
        HOLD:
          if (redirect) begin
            pc <= target;
            state <= misaligned ? FAULT : FETCH;
          end else if (instr_ready) begin
            pc <= pc_inc;
            state <= FETCH;
          end
        DISCARD:
          if (redirect) begin
            pc <= target;
            flt_pend <= misaligned;
          end else if (ack) state <= flt_pend ? FAULT : FETCH;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RV32I core. Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents the fetched word and its PC to decode; the word drives the immediate generator's instruction input.
- Consumes the generated immediate plus a base value from execute to compute branch/JAL/JALR redirect targets.
- Inserts bubbles on memory stalls and discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/data width (only 32 supported).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  XLEN  fetch address, stable while imem_req is high.
- imem_ack  in  1  memory response; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  instruction to decode/immediate generator.
- pc_out  out  XLEN  PC of instr_out.
- instr_valid  out  1  instr_out/pc_out valid.
- instr_ready  in  1  decode accepts instr_out this cycle.
- redirect  in  1  control-flow change from execute (taken branch, JAL, JALR).
- redirect_is_jalr  in  1  target bit0 cleared when high.
- redirect_base  in  XLEN  PC of redirecting instruction, or rs1 for JALR.
- immediate  in  XLEN  sign-extended immediate of redirecting instruction.
- fetch_fault  out  1  misaligned target trap (only with optional feature).

Behaviour:
- Reset (sync, active-high, any state): pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0, instr_out=32'h0000_0013 (NOP), pc_out=RESET_PC, fetch_fault=0. First request is issued the cycle after rst deasserts.
- Target: target = redirect_base + immediate, mod 2^32 (wrap, no overflow flag). If redirect_is_jalr, target[0]=0.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch instr_out=imem_rdata, pc_out=pc; go HOLD (instr_valid=1 next cycle). One-cycle minimum latency: ack in cycle N gives valid in N+1.
- State HOLD:
  - instr_valid=1, imem_req=0.
  - On instr_ready: pc=pc+4, go FETCH.
  - Otherwise hold all outputs unchanged.
- State DISCARD:
  - imem_req=1 with the saved stale address (handshake rule: address never changes while req is pending).
  - On imem_ack: drop the data, go FETCH using the updated pc.
- Redirect priority: redirect outranks instr_ready and imem_ack.
  - HOLD: pc=target, instr_valid=0 next cycle, go FETCH. The held instruction is dropped even if instr_ready is high.
  - FETCH with no ack this cycle: save the outstanding address, pc=target, go DISCARD.
  - FETCH with ack this cycle: drop the data, pc=target, go FETCH.
  - DISCARD: pc=target, stay DISCARD. The latest redirect wins.
- instr_valid never asserts for discarded data. instr_out is stable while instr_valid=1 and instr_ready=0.
- PC increment wraps: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Any imem_ack seen while imem_req=0 is ignored.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect whose final target[1:0] != 0 sets fetch_fault=1 and enters FAULT. In FAULT, imem_req=0 and instr_valid=0 until rst. If a request is outstanding when the fault occurs, complete it through DISCARD first, then enter FAULT.
- Undefined: target[1:0] is forced to 0, fetch_fault is tied 0, and the FAULT state is absent.

Decomposition:
- Shared package:
  - fetch state enum {FETCH, HOLD, DISCARD, FAULT}
  - NOP constant 32'h0000_0013
  - PC_INC constant 4
  - XLEN default
- One sub-module, next_pc_calc (combinational): computes pc+4, the target adder, the JALR bit0 clear and the misalignment flag.

Test Plan:
- Reset then ack every cycle it is requested, instr_ready=1 -> addresses 0x0,0x4,0x8; valid one cycle after each ack; pc_out matches.
- Ack delayed 3 cycles at addr 0x8 -> imem_req/imem_addr=0x8 held 4 cycles, instr_valid=0 throughout, one valid word follows.
- HOLD with instr_ready=0 for 5 cycles -> instr_out/pc_out stable, no new request, then pc advances by exactly 4.
- Redirect in FETCH, request pending at 0x10, base=0x0C, imm=0x100 -> addr 0x10 held until ack, that data is never valid, next request at 0x10C.
- JALR redirect, base=0x2001, imm=0x4 -> next fetch 0x2004; branch base=0x8, imm=-8 (0xFFFF_FFF8) -> next fetch 0x0.
- Redirect to 0x102 -> with FETCH_MISALIGN_TRAP_EN: fetch_fault=1, no further req until rst. Without it: fetch at 0x100.
